// File: rtl/tdc_pkg.sv
// Shared constants and elaboration-time helpers for the TDC popcount pipeline.
package tdc_pkg;

   // Bits counted by one leaf counter.
   localparam int GRP_SIZE = 6;

   // Number of leaf groups needed to cover w bits.
   function automatic int num_groups(input int w);
      return (w + GRP_SIZE - 1) / GRP_SIZE;
   endfunction

   // Smallest r with 2**r >= n (0 for n <= 1).
   function automatic int clog2_int(input int n);
      int r;
      r = 0;
      while ((1 << r) < n) r++;
      return r;
   endfunction

   // Pipeline depth: one leaf stage plus one stage per adder-tree level.
   function automatic int lat_of(input int w);
      return 1 + clog2_int(num_groups(w));
   endfunction

   // Width of the sums held at level lvl (level 1 is the leaf counts).
   function automatic int sum_w(input int lvl);
      return 3 + lvl - 1;
   endfunction

   // Nodes at level lvl when the tree starts with g leaves.
   function automatic int nodes_at(input int g, input int lvl);
      int n;
      n = g;
      for (int i = 1; i < lvl; i++) n = (n + 1) / 2;
      return n;
   endfunction

endpackage

// File: rtl/ones_counter_6to3.sv
// Purely combinational count of the ones in a 6-bit slice.
module ones_counter_6to3 (
   input  logic [5:0] i_Bits,
   output logic [2:0] o_Count
);

   // Add the six bits into a 3-bit count (max 6).
   always_comb begin
      o_Count = '0;
      for (int b = 0; b < 6; b++) o_Count = o_Count + 3'(i_Bits[b]);
   end

endmodule

// File: rtl/tdc_popcount_pipe.sv
// Pipelined popcount of a tapped-delay-line snapshot: a registered stage of
// 6-bit group counters followed by a registered binary adder tree. A valid
// bit rides alongside every stage; data registers only load when their
// incoming valid is set so idle cycles do not toggle the datapath.
// Handshake: i_Valid qualifies i_Sequence for one cycle with no backpressure;
// o_Valid qualifies o_Count, exactly LAT cycles after the matching i_Valid.
module tdc_popcount_pipe
   import tdc_pkg::*;
#(
   parameter int WIDTH = 192,
   parameter int CW    = $clog2(WIDTH + 1)
) (
   input  logic             i_Clk,
   input  logic             i_Rst_n,
   input  logic             i_Valid,
   input  logic [WIDTH-1:0] i_Sequence,
   output logic             o_Valid,
   output logic [CW-1:0]    o_Count,
   output logic [7:0]       o_Latency
);

   localparam int G   = num_groups(WIDTH);
   localparam int LAT = lat_of(WIDTH);

   logic [GRP_SIZE*G-1:0] seq_ext;
   logic [LAT-1:0]        vld_q;

   // Zero-extend the sample to a whole number of groups.
   always_comb begin
      seq_ext = '0;
      seq_ext[WIDTH-1:0] = i_Sequence;
   end

   // Valid shift register, one bit per pipeline stage.
   always_ff @(posedge i_Clk or negedge i_Rst_n) begin
      if (!i_Rst_n) begin
         vld_q <= '0;
      end else begin
         vld_q[0] <= i_Valid;
         for (int l = 1; l < LAT; l++) vld_q[l] <= vld_q[l-1];
      end
   end

   for (genvar l = 0; l < LAT; l++) begin : lvl
      localparam int SW = sum_w(l + 1);
      localparam int N  = nodes_at(G, l + 1);

      logic [SW-1:0] sum_d [N];
      logic [SW-1:0] sum_q [N];

      if (l == 0) begin : g_leaf
         for (genvar k = 0; k < G; k++) begin : g_grp
            ones_counter_6to3 u_cnt (
               .i_Bits  (seq_ext[GRP_SIZE*k +: GRP_SIZE]),
               .o_Count (sum_d[k])
            );
         end

         // Capture the group counts of an accepted sample.
         always_ff @(posedge i_Clk or negedge i_Rst_n) begin
            if (!i_Rst_n)     sum_q <= '{default: '0};
            else if (i_Valid) sum_q <= sum_d;
         end
      end else begin : g_add
         localparam int NP = nodes_at(G, l);

         for (genvar j = 0; j < N; j++) begin : g_node
            if (2*j + 1 < NP) begin : g_pair
               assign sum_d[j] = SW'(lvl[l-1].sum_q[2*j]) + SW'(lvl[l-1].sum_q[2*j+1]);
            end else begin : g_pass
               // Odd leftover node is carried up unchanged.
               assign sum_d[j] = SW'(lvl[l-1].sum_q[2*j]);
            end
         end

         // Register this tree level when the level below holds a valid sample.
         always_ff @(posedge i_Clk or negedge i_Rst_n) begin
            if (!i_Rst_n)        sum_q <= '{default: '0};
            else if (vld_q[l-1]) sum_q <= sum_d;
         end
      end
   end

   // The root sum never exceeds WIDTH, so truncating to CW bits is lossless.
   assign o_Count   = lvl[LAT-1].sum_q[0][CW-1:0];
   assign o_Valid   = vld_q[LAT-1];
   assign o_Latency = 8'(LAT);

endmodule
